// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue sequencer: op codes, rounding modes,
// per-class latencies and the sequencer state encoding.
package fpu_pkg;

   // Op codes (single codes and class ranges)
   localparam logic [4:0] FPU_FADD         = 5'b00000;
   localparam logic [4:0] FPU_FSUB         = 5'b00001;
   localparam logic [4:0] FPU_FMUL         = 5'b00010;
   localparam logic [4:0] FPU_FDIV         = 5'b00011;
   localparam logic [4:0] FPU_FSQRT        = 5'b00100;
   localparam logic [4:0] FPU_SIMPLE_LO    = 5'b00101;
   localparam logic [4:0] FPU_SIMPLE_HI    = 5'b01111;
   localparam logic [4:0] FPU_TOINT_LO     = 5'b01010;
   localparam logic [4:0] FPU_TOINT_HI     = 5'b01110;
   localparam logic [4:0] FPU_FMA_LO       = 5'b10000;
   localparam logic [4:0] FPU_FMA_HI       = 5'b10011;
   localparam logic [4:0] FPU_CVT_LO       = 5'b10100;
   localparam logic [4:0] FPU_CVT_TOINT_HI = 5'b10101;
   localparam logic [4:0] FPU_CVT_HI       = 5'b10111;
   localparam logic [4:0] FPU_NOP          = 5'b11111;

   // Rounding-mode encodings
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   // Latency in cycles from accept edge to writeback pulse
   localparam logic [4:0] LAT_ADD    = 5'd3;
   localparam logic [4:0] LAT_MUL    = 5'd4;
   localparam logic [4:0] LAT_DIV    = 5'd16;
   localparam logic [4:0] LAT_SIMPLE = 5'd1;
   localparam logic [4:0] LAT_FMA    = 5'd5;
   localparam logic [4:0] LAT_CVT    = 5'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } fpu_state_e;

   // Encodings 101/110/111 are reserved once the dynamic mode has been resolved
   function automatic logic rm_reserved(input logic [2:0] r);
      return (r > RM_RMM);
   endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Op-class lookup: latency, whether the op consumes a rounding mode, and
// whether its result goes to the integer register file.
module fpu_lat_lut (
   input  logic [4:0] fpusel,
   output logic [4:0] lat,
   output logic       uses_rm,
   output logic       to_int
);
   import fpu_pkg::*;

   // Decode the op class; unlisted codes behave as single-cycle, no-rm ops
   always_comb begin
      lat     = LAT_SIMPLE;
      uses_rm = 1'b0;
      to_int  = 1'b0;
      if (fpusel == FPU_FADD || fpusel == FPU_FSUB) begin
         lat     = LAT_ADD;
         uses_rm = 1'b1;
      end else if (fpusel == FPU_FMUL) begin
         lat     = LAT_MUL;
         uses_rm = 1'b1;
      end else if (fpusel == FPU_FDIV || fpusel == FPU_FSQRT) begin
         lat     = LAT_DIV;
         uses_rm = 1'b1;
      end else if (fpusel >= FPU_SIMPLE_LO && fpusel <= FPU_SIMPLE_HI) begin
         lat     = LAT_SIMPLE;
         to_int  = (fpusel >= FPU_TOINT_LO && fpusel <= FPU_TOINT_HI);
      end else if (fpusel >= FPU_FMA_LO && fpusel <= FPU_FMA_HI) begin
         lat     = LAT_FMA;
         uses_rm = 1'b1;
      end else if (fpusel >= FPU_CVT_LO && fpusel <= FPU_CVT_HI) begin
         lat     = LAT_CVT;
         uses_rm = 1'b1;
         to_int  = (fpusel <= FPU_CVT_TOINT_HI);
      end
   end

endmodule

// File: rtl/fpu_issue_seq.sv
// FPU issue sequencer: accepts one decoded FP op at a time, times its
// latency and emits a writeback pulse. WB is the last cycle of an op; the
// registered wb_valid pulse appears on the edge that leaves WB, so a new op
// can be accepted in WB while the previous result is being written back.
module fpu_issue_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   input  logic [4:0] fpusel_s,
   input  logic [2:0] rm,
   input  logic [4:0] rd,
   input  logic       illegal_ins,
   input  logic       flush,
   input  logic [2:0] fcsr_frm,
   output logic       op_ready,
   output logic       fpu_hazard,
   output logic       fpu_start,
   output logic [4:0] fpu_sel,
   output logic [2:0] fpu_rm,
   output logic       wb_valid,
   output logic [4:0] wb_rd,
   output logic       wb_int,
   output logic       rm_illegal
);
   import fpu_pkg::*;

   fpu_state_e state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic       start_q, start_d;
   logic       wbv_q, wbv_d;
   logic [4:0] sel_q, sel_d;
   logic [2:0] frm_q, frm_d;
   logic [4:0] wb_rd_q, wb_rd_d;
   logic       wb_int_q, wb_int_d;
   // Destination of the op in flight; copied to wb_rd/wb_int on writeback so a
   // back-to-back accept cannot overwrite the metadata of the completing op.
   logic [4:0] tgt_rd_q, tgt_rd_d;
   logic       tgt_int_q, tgt_int_d;

   logic [4:0] lut_lat;
   logic       lut_uses_rm;
   logic       lut_to_int;
   logic [2:0] rm_res;
   logic       accept;

   fpu_lat_lut u_lut (
      .fpusel  (fpusel_s),
      .lat     (lut_lat),
      .uses_rm (lut_uses_rm),
      .to_int  (lut_to_int)
   );

   // Handshake: ready/hazard, rounding-mode resolution and accept qualification
   always_comb begin
      rm_res     = (rm == RM_DYN) ? fcsr_frm : rm;
      op_ready   = (state_q != ST_EXEC);
      fpu_hazard = op_valid && !op_ready;
      rm_illegal = op_valid && op_ready && !illegal_ins && lut_uses_rm && rm_reserved(rm_res);
      accept     = op_valid && op_ready && !flush && !illegal_ins &&
                   (fpusel_s != FPU_NOP) && !rm_illegal;
   end

   // Next-state: sequencing, latency counter, output register updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_d   = 1'b0;
      wbv_d     = 1'b0;
      sel_d     = sel_q;
      frm_d     = frm_q;
      wb_rd_d   = wb_rd_q;
      wb_int_d  = wb_int_q;
      tgt_rd_d  = tgt_rd_q;
      tgt_int_d = tgt_int_q;
      case (state_q)
         ST_IDLE, ST_WB: begin
            if (state_q == ST_WB && !flush) begin
               wbv_d    = 1'b1;
               wb_rd_d  = tgt_rd_q;
               wb_int_d = tgt_int_q;
            end
            if (accept) begin
               start_d   = 1'b1;
               sel_d     = fpusel_s;
               frm_d     = lut_uses_rm ? rm_res : RM_RNE;
               tgt_rd_d  = rd;
               tgt_int_d = lut_to_int;
               if (state_q == ST_IDLE) begin
                  wb_rd_d  = rd;
                  wb_int_d = lut_to_int;
               end
               if (lut_lat == LAT_SIMPLE) begin
                  state_d = ST_WB;
                  cnt_d   = 5'd0;
               end else begin
                  state_d = ST_EXEC;
                  cnt_d   = lut_lat - 5'd1;
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
            end
         end
         ST_EXEC: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
            end else if (cnt_q == 5'd1) begin
               state_d = ST_WB;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         start_q   <= 1'b0;
         wbv_q     <= 1'b0;
         sel_q     <= FPU_NOP;
         frm_q     <= RM_RNE;
         wb_rd_q   <= 5'd0;
         wb_int_q  <= 1'b0;
         tgt_rd_q  <= 5'd0;
         tgt_int_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         wbv_q     <= wbv_d;
         sel_q     <= sel_d;
         frm_q     <= frm_d;
         wb_rd_q   <= wb_rd_d;
         wb_int_q  <= wb_int_d;
         tgt_rd_q  <= tgt_rd_d;
         tgt_int_q <= tgt_int_d;
      end
   end

   assign fpu_start = start_q;
   assign wb_valid  = wbv_q;
   assign fpu_sel   = sel_q;
   assign fpu_rm    = frm_q;
   assign wb_rd     = wb_rd_q;
   assign wb_int    = wb_int_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Testbench for fpu_issue_seq: a table of single ops, hand-written
// multi-cycle sequences, then random traffic against a timeline model.
module tb_fpu_issue_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic [4:0] fpusel_s;
   logic [2:0] rm;
   logic [4:0] rd;
   logic       illegal_ins;
   logic       flush;
   logic [2:0] fcsr_frm;
   logic       op_ready, fpu_hazard, fpu_start, wb_valid, wb_int, rm_illegal;
   logic [4:0] fpu_sel, wb_rd;
   logic [2:0] fpu_rm;

   int checks = 0;
   int errors = 0;

   fpu_issue_seq dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .fpusel_s(fpusel_s), .rm(rm),
      .rd(rd), .illegal_ins(illegal_ins), .flush(flush), .fcsr_frm(fcsr_frm),
      .op_ready(op_ready), .fpu_hazard(fpu_hazard), .fpu_start(fpu_start),
      .fpu_sel(fpu_sel), .fpu_rm(fpu_rm), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_int(wb_int), .rm_illegal(rm_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_fpu_start"}, fpu_start, 0);
      chk({tag, "_wb_valid"}, wb_valid, 0);
      chk({tag, "_fpu_sel"}, fpu_sel, 5'b11111);
      chk({tag, "_fpu_rm"}, fpu_rm, 0);
      chk({tag, "_wb_rd"}, wb_rd, 0);
      chk({tag, "_wb_int"}, wb_int, 0);
      chk({tag, "_op_ready"}, op_ready, 1);
   endtask

   task automatic idle_in();
      op_valid = 0; fpusel_s = 5'b11111; rm = 0; rd = 0;
      illegal_ins = 0; flush = 0; fcsr_frm = 0;
   endtask

   task automatic set_op(input logic [4:0] s, input logic [2:0] r, input logic [2:0] f,
                         input logic [4:0] d);
      op_valid = 1; fpusel_s = s; rm = r; fcsr_frm = f; rd = d;
   endtask

   // ---------------- reference rules ----------------
   function automatic int lat_of(input logic [4:0] s);
      if (s <= 1) return 3;
      if (s == 2) return 4;
      if (s <= 4) return 16;
      if (s <= 15) return 1;
      if (s <= 19) return 5;
      if (s <= 23) return 2;
      return 1;
   endfunction
   function automatic logic uses_rm_of(input logic [4:0] s);
      return (s <= 4) || (s >= 16 && s <= 23);
   endfunction
   function automatic logic to_int_of(input logic [4:0] s);
      return (s >= 10 && s <= 14) || s == 20 || s == 21;
   endfunction

   // ---------------- timeline model ----------------
   // An accepted op occupies the sequencer until absolute cycle m_done-1
   // (its last, ready cycle); its writeback is visible in cycle m_done.
   int         cyc = 0;
   int         m_done = 0;
   logic       m_pend = 0, m_start = 0, m_wb = 0;
   logic [4:0] m_sel = 5'b11111, m_tgt_rd = 0, m_wb_rd = 0;
   logic [2:0] m_rm = 0;
   logic       m_tgt_int = 0, m_wb_int = 0;

   task automatic model_reset();
      m_pend = 0; m_start = 0; m_wb = 0; m_sel = 5'b11111; m_rm = 0;
      m_wb_rd = 0; m_wb_int = 0;
   endtask

   task automatic step(input logic v, input logic [4:0] s, input logic [2:0] r,
                       input logic [2:0] f, input logic [4:0] d, input logic il, input logic fl);
      logic [2:0] res;
      logic xr, xh, xri, xa, wbn, last;
      @(negedge clk);
      op_valid = v; fpusel_s = s; rm = r; fcsr_frm = f; rd = d; illegal_ins = il; flush = fl;
      #1;
      res  = (r == 3'b111) ? f : r;
      last = m_pend && (cyc == m_done - 1);
      xr   = !m_pend || last;
      xh   = v && !xr;
      xri  = v && xr && !il && uses_rm_of(s) && (res >= 3'd5);
      xa   = v && xr && !fl && !il && (s != 5'b11111) && !xri;
      chk("rnd_op_ready", op_ready, xr);
      chk("rnd_fpu_hazard", fpu_hazard, xh);
      chk("rnd_rm_illegal", rm_illegal, xri);
      chk("rnd_fpu_start", fpu_start, m_start);
      chk("rnd_wb_valid", wb_valid, m_wb);
      if (m_wb) begin
         chk("rnd_wb_rd", wb_rd, m_wb_rd);
         chk("rnd_wb_int", wb_int, m_wb_int);
      end
      chk("rnd_fpu_sel", fpu_sel, m_sel);
      chk("rnd_fpu_rm", fpu_rm, m_rm);
      wbn = last && !fl;
      if (wbn) begin
         m_wb_rd = m_tgt_rd; m_wb_int = m_tgt_int;
      end
      if (m_pend && (fl || last)) m_pend = 0;
      if (xa) begin
         m_pend = 1; m_done = cyc + 1 + lat_of(s);
         m_tgt_rd = d; m_tgt_int = to_int_of(s);
         m_sel = s; m_rm = uses_rm_of(s) ? res : 3'd0;
      end
      m_start = xa; m_wb = wbn;
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_in();
      #2 rst = 1;
      #1 chk_reset_vals("rnd_reset");
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   // ---------------- table of single ops ----------------
   typedef struct {
      logic [4:0] sel; logic [2:0] rmv; logic [2:0] frm; logic [4:0] rdv;
      int lat; logic [2:0] xrm; logic xint; logic xill;
   } vec_t;
   vec_t vecs[16];

   initial begin
      vec_t v;
      int got, haz, nwb;
      idle_in();
      rst = 1;
      vecs[0]  = '{5'b00000, 3'b000, 3'b000, 5'd5,  3,  3'b000, 1'b0, 1'b0};
      vecs[1]  = '{5'b00001, 3'b001, 3'b000, 5'd6,  3,  3'b001, 1'b0, 1'b0};
      vecs[2]  = '{5'b00010, 3'b111, 3'b101, 5'd7,  0,  3'b000, 1'b0, 1'b1};
      vecs[3]  = '{5'b00010, 3'b111, 3'b010, 5'd7,  4,  3'b010, 1'b0, 1'b0};
      vecs[4]  = '{5'b00011, 3'b011, 3'b000, 5'd8,  16, 3'b011, 1'b0, 1'b0};
      vecs[5]  = '{5'b00100, 3'b100, 3'b000, 5'd9,  16, 3'b100, 1'b0, 1'b0};
      vecs[6]  = '{5'b00101, 3'b110, 3'b000, 5'd10, 1,  3'b000, 1'b0, 1'b0};
      vecs[7]  = '{5'b01010, 3'b010, 3'b000, 5'd11, 1,  3'b000, 1'b1, 1'b0};
      vecs[8]  = '{5'b01110, 3'b000, 3'b000, 5'd12, 1,  3'b000, 1'b1, 1'b0};
      vecs[9]  = '{5'b01111, 3'b000, 3'b000, 5'd13, 1,  3'b000, 1'b0, 1'b0};
      vecs[10] = '{5'b10000, 3'b000, 3'b011, 5'd14, 5,  3'b000, 1'b0, 1'b0};
      vecs[11] = '{5'b10011, 3'b110, 3'b000, 5'd15, 0,  3'b000, 1'b0, 1'b1};
      vecs[12] = '{5'b10100, 3'b001, 3'b000, 5'd16, 2,  3'b001, 1'b1, 1'b0};
      vecs[13] = '{5'b10101, 3'b111, 3'b100, 5'd17, 2,  3'b100, 1'b1, 1'b0};
      vecs[14] = '{5'b10110, 3'b000, 3'b000, 5'd18, 2,  3'b000, 1'b0, 1'b0};
      vecs[15] = '{5'b10111, 3'b101, 3'b000, 5'd19, 0,  3'b000, 1'b0, 1'b1};

      // Reset state, then first accept on the first edge after release
      @(negedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      rst = 0;
      set_op(5'b00000, 3'b000, 3'b000, 5'd5);
      @(posedge clk); #1;
      idle_in();
      chk("first_accept_start", fpu_start, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk("fadd_wb_valid", wb_valid, (k == 3));
      end
      chk("fadd_wb_rd", wb_rd, 5);
      chk("fadd_wb_int", wb_int, 0);

      // Table: each op alone, latency measured from its accept edge
      for (int i = 0; i < 16; i++) begin
         v = vecs[i];
         @(negedge clk);
         set_op(v.sel, v.rmv, v.frm, v.rdv);
         #1;
         chk("tbl_op_ready", op_ready, 1);
         chk("tbl_rm_illegal", rm_illegal, v.xill);
         @(posedge clk); #1;
         idle_in();
         chk("tbl_fpu_start", fpu_start, !v.xill);
         if (!v.xill) begin
            chk("tbl_fpu_sel", fpu_sel, v.sel);
            chk("tbl_fpu_rm", fpu_rm, v.xrm);
            got = -1;
            for (int k = 1; k <= 24; k++) begin
               @(posedge clk); #1;
               if (wb_valid) begin got = k; break; end
            end
            chk("tbl_latency", got, v.lat);
            chk("tbl_wb_rd", wb_rd, v.rdv);
            chk("tbl_wb_int", wb_int, v.xint);
         end else begin
            repeat (2) @(posedge clk);
            #1 chk("tbl_illegal_no_wb", wb_valid, 0);
         end
      end

      // fdiv with a second op held: 15 hazard cycles, second accepted in WB
      @(negedge clk);
      set_op(5'b00011, 3'b000, 3'b000, 5'd12);
      @(posedge clk); #1;
      chk("div_start", fpu_start, 1);
      set_op(5'b00000, 3'b000, 3'b000, 5'd9);
      haz = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (fpu_hazard) haz++; else break;
      end
      chk("div_hazard_cycles", haz, 15);
      chk("div_ready_in_wb", op_ready, 1);
      @(posedge clk); #1;
      idle_in();
      chk("div_wb_valid", wb_valid, 1);
      chk("div_wb_rd", wb_rd, 12);
      chk("div_second_start", fpu_start, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk("div_second_wb", wb_valid, (k == 3));
      end
      chk("div_second_wb_rd", wb_rd, 9);

      // feq then back-to-back fcvt.w.s
      @(negedge clk);
      set_op(5'b01010, 3'b000, 3'b000, 5'd3);
      @(posedge clk); #1;
      set_op(5'b10100, 3'b000, 3'b000, 5'd4);
      @(posedge clk); #1;
      idle_in();
      chk("feq_wb_valid", wb_valid, 1);
      chk("feq_wb_rd", wb_rd, 3);
      chk("feq_wb_int", wb_int, 1);
      chk("fcvt_start", fpu_start, 1);
      @(posedge clk); #1;
      chk("fcvt_wb_early", wb_valid, 0);
      @(posedge clk); #1;
      chk("fcvt_wb_valid", wb_valid, 1);
      chk("fcvt_wb_rd", wb_rd, 4);
      chk("fcvt_wb_int", wb_int, 1);

      // fmadd flushed two cycles after accept
      @(negedge clk);
      set_op(5'b10000, 3'b000, 3'b000, 5'd8);
      @(posedge clk); #1;
      idle_in();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fma_busy", op_ready, 0);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("fma_flush_ready", op_ready, 1);
      nwb = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (wb_valid) nwb++;
      end
      chk("fma_flush_no_wb", nwb, 0);

      // Flush during the WB cycle suppresses the writeback
      @(negedge clk);
      set_op(5'b00001, 3'b000, 3'b000, 5'd21);
      @(posedge clk); #1;
      idle_in();
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("wb_flush_no_wb", wb_valid, 0);
      chk("wb_flush_ready", op_ready, 1);

      // Flush, illegal_ins and NOP code each block the accept
      @(negedge clk);
      set_op(5'b00000, 3'b000, 3'b000, 5'd1);
      flush = 1;
      @(posedge clk); #1;
      chk("flush_blocks_accept", fpu_start, 0);
      flush = 0; illegal_ins = 1;
      @(posedge clk); #1;
      chk("illegal_blocks_accept", fpu_start, 0);
      illegal_ins = 0; fpusel_s = 5'b11111;
      @(posedge clk); #1;
      chk("nop_blocks_accept", fpu_start, 0);
      idle_in();

      // Reset in the middle of fsqrt
      @(negedge clk);
      set_op(5'b00100, 3'b000, 3'b000, 5'd20);
      @(posedge clk); #1;
      idle_in();
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst = 1;
      #1 chk_reset_vals("mid_sqrt_reset");
      @(negedge clk);
      rst = 0;
      nwb = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (wb_valid) nwb++;
      end
      chk("mid_sqrt_no_wb", nwb, 0);

      // Random traffic against the timeline model
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            logic [4:0] s;
            s = ($urandom_range(0, 24) == 24) ? 5'b11111 : 5'($urandom_range(0, 23));
            step($urandom_range(0, 9) < 6, s, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
